reg_bank_reader: RTL and testbench
==================================

REG_BANK_READER -- requirements
Module: reg_bank_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width of bank registers and output.
REQ-002 Parameter ADDR_WIDTH, default 3, bank address width (8 registers).
REQ-003 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a burst read; sampled only in IDLE.
REQ-007 first_addr  input  ADDR_WIDTH  first bank address of the burst; captured with start.
REQ-008 count  input  ADDR_WIDTH+1  number of words to read (0..2^ADDR_WIDTH); captured with start.
REQ-009 rd_addr  output  ADDR_WIDTH  bank read address.
REQ-010 rd_enable  output  1  bank read strobe; one cycle per word.
REQ-011 rd_data  input  DATA_WIDTH  bank read data, valid exactly one cycle after the rd_enable cycle.
REQ-012 out_data  output  DATA_WIDTH  streamed word.
REQ-013 out_valid  output  1  out_data valid; held until accepted.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at burst end.

Function
REQ-017 FSM states SHALL be IDLE, READ, WAIT, OUT, DONE.
REQ-018 IDLE: start=1 with count>0 -> capture first_addr/count, go READ; start=1 with count=0 -> go DONE; else stay.
REQ-019 READ: rd_enable=1, rd_addr=current address for exactly one cycle; go WAIT.
REQ-020 WAIT: register rd_data into out_data at the edge ending WAIT; go OUT.
REQ-021 OUT: out_valid=1, out_data stable; on out_valid&&out_ready at edge, decrement remaining, increment address; remaining becomes 0 -> DONE, else -> READ.
REQ-022 DONE: done=1 for one cycle; go IDLE.
REQ-023 Latency: start edge to first out_valid SHALL be 3 cycles; each subsequent word 3 cycles after prior acceptance when out_ready is held high.
REQ-024 Address SHALL wrap modulo 2^ADDR_WIDTH (e.g. first_addr=7, count=2 reads 7 then 0).
REQ-025 start while busy SHALL be ignored; captured first_addr/count SHALL not change mid-burst.
REQ-026 out_ready high outside OUT SHALL have no effect; out_ready low in OUT SHALL stall indefinitely with out_data unchanged.
REQ-027 rd_enable SHALL be 0 in all states except READ; rd_addr SHALL hold its last value outside READ.
REQ-028 count=2^ADDR_WIDTH SHALL read every register once.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE regardless of state, including mid-burst, aborting without done.
REQ-030 Reset values: rd_addr=0, rd_enable=0, out_data=0, out_valid=0, busy=0, done=0, internal address/remaining=0.
REQ-031 reset SHALL take priority over start in the same cycle.

Configuration
REQ-032 Macro READER_CHECKSUM_EN defined: add output checksum (DATA_WIDTH), sum modulo 2^DATA_WIDTH of all accepted words of the current burst, cleared on accepted start, valid and stable from the done cycle until next accepted start; reset value 0.
REQ-033 READER_CHECKSUM_EN undefined: no checksum port, no accumulator logic; all other behaviour identical.

Verification
REQ-034 Bank reg i = 16'h1000+i, reg2 = 16'h6666; start, first_addr=2, count=1, out_ready=1 -> rd_enable one cycle with rd_addr=2, out_data=16'h6666 valid 3 cycles after start, done pulse next cycle.
REQ-035 first_addr=6, count=4, out_ready=1 -> words 16'h1006, 16'h1007, 16'h1000, 16'h1001 in order (wrap), single done; with checksum enabled checksum=16'h400E.
REQ-036 first_addr=0, count=2, out_ready low 10 cycles after first out_valid -> out_data=16'h1000 held 10 cycles, no extra rd_enable, then second word 16'h1001.
REQ-037 count=0 with start -> no rd_enable, no out_valid, done one cycle after start, busy high only in that DONE cycle.
REQ-038 reset asserted in OUT of a count=3 burst -> next cycle all outputs at reset values, no done; start pulsed during burst (first_addr=5) -> ignored, addresses unaffected.

Source files
------------

// File: rtl/reg_bank_reader.sv
// reg_bank_reader: reads a burst of bank registers and streams them out over valid/ready.
// Define READER_CHECKSUM_EN to add a running sum of the words accepted in the current burst.
module reg_bank_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_enable,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
`ifdef READER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, DONE} state_t;
    localparam logic [ADDR_WIDTH:0] last_word = 1;
    state_t state, next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0] remaining;
    logic launch, accept;
    assign launch = state == IDLE && start && count != '0;
    assign accept = state == OUT && out_ready;
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = count != '0 ? READ : DONE;
            READ: next_state = WAIT;
            WAIT: next_state = OUT;
            OUT: if (out_ready) next_state = remaining == last_word ? DONE : READ;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        rd_enable = state == READ;
        out_valid = state == OUT;
        busy = state != IDLE;
        done = state == DONE;
    end
    // rd_addr only moves when another read is coming, so it holds the last address afterwards
    always_ff @(posedge clock) begin
        if (reset) begin
            addr <= '0;
            remaining <= '0;
            rd_addr <= '0;
            out_data <= '0;
        end else begin
            if (launch) begin
                addr <= first_addr;
                remaining <= count;
                rd_addr <= first_addr;
            end
            if (state == WAIT) out_data <= rd_data;
            if (accept) begin
                addr <= addr + 1'b1;
                remaining <= remaining - 1'b1;
                if (remaining != last_word) rd_addr <= addr + 1'b1;
            end
        end
    end
`ifdef READER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) checksum <= '0;
        else if (state == IDLE && start) checksum <= '0;
        else if (accept) checksum <= checksum + out_data;
    end
`endif
endmodule

// File: tb/tb_reg_bank_reader.sv
// tb_reg_bank_reader: directed tests of reg_bank_reader against a behavioural register bank.
module tb_reg_bank_reader;
    logic clock = 1'b0;
    logic reset, start, out_ready;
    logic [2:0] first_addr, rd_addr;
    logic [3:0] count;
    logic rd_enable, out_valid, busy, done;
    logic [15:0] rd_data, out_data, held;
`ifdef READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif
    logic [15:0] bank [8];
    logic [15:0] words [16];
    logic [2:0] raddr [16];
    int vcyc [16];
    int checks = 0, failures = 0;
    int n_words, n_rd, n_done, n_busy, n_valid, done_cyc, n_stall, held_bad;

    reg_bank_reader dut (
        .clock(clock), .reset(reset), .start(start), .first_addr(first_addr), .count(count),
        .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
`ifdef READER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) rd_data <= rd_enable ? bank[rd_addr] : 16'hDEAD;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // cycle 0 is the cycle start is presented; records everything seen until shortly after done
    task automatic run_burst(input logic [2:0] fa, input logic [3:0] cnt, input int stall);
        int cyc, stall_left;
        n_words = 0; n_rd = 0; n_done = 0; n_busy = 0; n_valid = 0; done_cyc = -1;
        n_stall = 0; held_bad = 0; held = '0; stall_left = stall;
        first_addr = fa; count = cnt; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (cyc < 200 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
            if (busy) n_busy++;
            if (rd_enable) begin
                if (n_rd < 16) raddr[n_rd] = rd_addr;
                n_rd++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (out_valid) begin
                n_valid++;
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    if (n_stall == 0) held = out_data;
                    else if (out_data !== held) held_bad++;
                    n_stall++;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    if (n_words < 16) begin
                        words[n_words] = out_data;
                        vcyc[n_words] = cyc;
                    end
                    n_words++;
                end
            end
            step();
            cyc++;
        end
        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL burst_timeout no done within 200 cycles fa=%0d cnt=%0d", fa, cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; first_addr = '0; count = '0;
        step();
        step();
        checks++;
        if ({rd_addr, rd_enable, out_data, out_valid, busy, done} !== 23'd0) begin
            failures++;
            $display("FAIL reset_values got rd_addr=%0d rd_en=%b out=%h valid=%b busy=%b done=%b exp all 0",
                     rd_addr, rd_enable, out_data, out_valid, busy, done);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        first_addr = 3'd2; count = 4'd1; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (rd_enable !== 1'b1 || rd_addr !== 3'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_read got rd_en=%b rd_addr=%0d busy=%b exp 1,2,1", rd_enable, rd_addr, busy);
        end
        step();
        checks++;
        if (rd_enable !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_wait got rd_en=%b valid=%b exp 0,0", rd_enable, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h6666 || done !== 1'b0) begin
            failures++;
            $display("FAIL single_out got valid=%b data=%h done=%b exp 1,6666,0", out_valid, out_data, done);
        end
        step();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_done got done=%b valid=%b busy=%b exp 1,0,1", done, out_valid, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rd_addr !== 3'd2) begin
            failures++;
            $display("FAIL single_idle got done=%b busy=%b rd_addr=%0d exp 0,0,2", done, busy, rd_addr);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w [4] = '{16'h1006, 16'h1007, 16'h1000, 16'h1001};
        logic [2:0] exp_a [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
        int exp_c [4] = '{3, 6, 9, 12};
        run_burst(3'd6, 4'd4, 0);
        checks++;
        if (n_words !== 4 || n_rd !== 4 || n_done !== 1 || done_cyc !== 13) begin
            failures++;
            $display("FAIL wrap_counts got words=%0d reads=%0d dones=%0d done_cyc=%0d exp 4,4,1,13",
                     n_words, n_rd, n_done, done_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (words[i] !== exp_w[i] || raddr[i] !== exp_a[i] || vcyc[i] !== exp_c[i]) begin
                failures++;
                $display("FAIL wrap_word%0d got data=%h addr=%0d cyc=%0d exp %h,%0d,%0d",
                         i, words[i], raddr[i], vcyc[i], exp_w[i], exp_a[i], exp_c[i]);
            end
        end
`ifdef READER_CHECKSUM_EN
        checks++;
        if (checksum !== 16'h400E) begin
            failures++;
            $display("FAIL wrap_checksum got=%h exp=400e", checksum);
        end
`endif
    endtask

    task automatic test_stall();
        run_burst(3'd0, 4'd2, 10);
        checks++;
        if (n_stall !== 10 || held_bad !== 0 || held !== 16'h1000) begin
            failures++;
            $display("FAIL stall_hold got stalls=%0d changes=%0d held=%h exp 10,0,1000", n_stall, held_bad, held);
        end
        checks++;
        if (n_rd !== 2 || n_words !== 2 || words[0] !== 16'h1000 || words[1] !== 16'h1001) begin
            failures++;
            $display("FAIL stall_words got reads=%0d words=%0d w0=%h w1=%h exp 2,2,1000,1001",
                     n_rd, n_words, words[0], words[1]);
        end
        checks++;
        if (vcyc[0] !== 13 || vcyc[1] !== 16 || done_cyc !== 17) begin
            failures++;
            $display("FAIL stall_timing got acc0=%0d acc1=%0d done=%0d exp 13,16,17", vcyc[0], vcyc[1], done_cyc);
        end
    endtask

    task automatic test_zero_count();
        run_burst(3'd4, 4'd0, 0);
        checks++;
        if (n_rd !== 0 || n_valid !== 0 || n_done !== 1 || done_cyc !== 1 || n_busy !== 1) begin
            failures++;
            $display("FAIL zero_count got reads=%0d valids=%0d dones=%0d done_cyc=%0d busy_cyc=%0d exp 0,0,1,1,1",
                     n_rd, n_valid, n_done, done_cyc, n_busy);
        end
    endtask

    task automatic test_full_bank();
        logic [15:0] exp_w [8] = '{16'h1003, 16'h1004, 16'h1005, 16'h1006,
                                   16'h1007, 16'h1000, 16'h1001, 16'h6666};
        run_burst(3'd3, 4'd8, 0);
        checks++;
        if (n_words !== 8 || n_rd !== 8 || n_done !== 1) begin
            failures++;
            $display("FAIL full_counts got words=%0d reads=%0d dones=%0d exp 8,8,1", n_words, n_rd, n_done);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (words[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL full_word%0d got=%h exp=%h", i, words[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int stray_done = 0;
        first_addr = 3'd0; count = 4'd3; start = 1'b1; out_ready = 1'b1;
        step();
        first_addr = 3'd5; count = 4'd2;
        step();
        start = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1000) begin
            failures++;
            $display("FAIL ignore_start_w0 got valid=%b data=%h exp 1,1000", out_valid, out_data);
        end
        step();
        checks++;
        if (rd_enable !== 1'b1 || rd_addr !== 3'd1) begin
            failures++;
            $display("FAIL ignore_start_addr got rd_en=%b rd_addr=%0d exp 1,1", rd_enable, rd_addr);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1001) begin
            failures++;
            $display("FAIL ignore_start_w1 got valid=%b data=%h exp 1,1001", out_valid, out_data);
        end
        reset = 1'b1; start = 1'b1; count = 4'd1;
        step();
        start = 1'b0;
        checks++;
        if ({rd_addr, rd_enable, out_data, out_valid, busy, done} !== 23'd0) begin
            failures++;
            $display("FAIL abort_values got rd_addr=%0d rd_en=%b out=%h valid=%b busy=%b done=%b exp all 0",
                     rd_addr, rd_enable, out_data, out_valid, busy, done);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) stray_done++;
        end
        checks++;
        if (stray_done !== 0) begin
            failures++;
            $display("FAIL abort_no_done got busy_or_done_cycles=%0d exp 0", stray_done);
        end
`ifdef READER_CHECKSUM_EN
        checks++;
        if (checksum !== 16'h0000) begin
            failures++;
            $display("FAIL abort_checksum got=%h exp=0000", checksum);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 8; i++) bank[i] = 16'h1000 + 16'(i);
        bank[2] = 16'h6666;
        test_reset();
        test_single();
        test_wrap();
        test_stall();
        test_zero_count();
        test_full_bank();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
